// File: rtl/fib_seq_ctrl.sv
// Moore FSM sequencing a two-register Fibonacci datapath (A, B, adder).
// Optional `define FIB_ABORT_EN adds an abort input that cancels a run in INIT/ADD.
module fib_seq_ctrl #(
  parameter int unsigned N_W = 5
) (
  input  logic           clk,
  input  logic           CLR_n,
  input  logic           start,
  input  logic [N_W-1:0] n,
  input  logic           carry,
`ifdef FIB_ABORT_EN
  input  logic           abort,
`endif
  output logic           busy,
  output logic           done,
  output logic           ovf,
  output logic           ldA,
  output logic           selA,
  output logic           ldB,
  output logic           selB,
  output logic [N_W-1:0] cnt
);

  typedef enum logic [1:0] {
    StIdle,
    StInit,
    StAdd,
    StDone
  } state_e;

  state_e         state_q, state_d;
  logic [N_W-1:0] n_reg_q, n_reg_d;
  logic [N_W-1:0] cnt_q, cnt_d;
  logic           ovf_q, ovf_d;
  logic [N_W-1:0] cnt_inc;
  logic           abort_hit;

  assign cnt_inc = cnt_q + 1'b1;

`ifdef FIB_ABORT_EN
  assign abort_hit = abort && ((state_q == StInit) || (state_q == StAdd));
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge CLR_n) begin
    if (!CLR_n) begin
      state_q <= StIdle;
      n_reg_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_reg_q <= n_reg_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_reg_d = n_reg_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    busy    = 1'b0;
    done    = 1'b0;
    ldA     = 1'b0;
    selA    = 1'b0;
    ldB     = 1'b0;
    selB    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          n_reg_d = n;
          state_d = StInit;
        end
      end
      StInit: begin
        busy    = 1'b1;
        ldA     = 1'b1;
        ldB     = 1'b1;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        state_d = (n_reg_q == '0) ? StDone : StAdd;
      end
      StAdd: begin
        busy    = 1'b1;
        ldA     = 1'b1;
        selA    = 1'b1;
        ldB     = 1'b1;
        selB    = 1'b1;
        cnt_d   = cnt_inc;
        if (carry) begin
          ovf_d = 1'b1;
        end
        // cnt never wraps: the run stops once cnt reaches n_reg
        state_d = (cnt_inc == n_reg_q) ? StDone : StAdd;
      end
      StDone: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort wins over every transition and freezes cnt/ovf at their current values
    if (abort_hit) begin
      ldA     = 1'b0;
      ldB     = 1'b0;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      state_d = StIdle;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;

endmodule
